// File: rtl/rv32m_pkg.sv
// Shared RV32M definitions: operand width, divide funct3 encodings and divider FSM states.
package rv32m_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] M_DIV  = 3'b100;
    localparam logic [2:0] M_DIVU = 3'b101;
    localparam logic [2:0] M_REM  = 3'b110;
    localparam logic [2:0] M_REMU = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

endpackage

// File: rtl/div_restore_step.sv
// One radix-2 restoring division step: shifts the next dividend bit into the
// partial remainder and subtracts the divisor if it fits.
module div_restore_step #(
    parameter int W = 32
) (
    input  logic [W-1:0] rem,
    input  logic         quo_msb,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] next_rem,
    output logic         q_bit
);

    logic [W:0] shifted;
    logic [W:0] trial;

    // The trial subtraction is one bit wider so its sign bit says whether the divisor fit.
    always_comb begin
        shifted  = {rem, quo_msb};
        trial    = shifted - {1'b0, divisor};
        q_bit    = ~trial[W];
        next_rem = q_bit ? trial[W-1:0] : shifted[W-1:0];
    end

endmodule

// File: rtl/m_ext_iter_divider.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU: one quotient bit per cycle,
// with sign fix-up and the RISC-V divide-by-zero / overflow results.
module m_ext_iter_divider
    import rv32m_pkg::*;
#(
    parameter int XLEN_P = XLEN,
    parameter int CNT_W  = $clog2(XLEN_P)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              flush,
    input  logic [2:0]        funct3,
    input  logic [XLEN_P-1:0] dividend,
    input  logic [XLEN_P-1:0] divisor,
    output logic              ready,
    output logic              done,
    output logic [XLEN_P-1:0] result
);

    localparam logic [XLEN_P-1:0] MOST_NEG = {1'b1, {(XLEN_P-1){1'b0}}};
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(XLEN_P - 1);

    div_state_t        state;
    logic [XLEN_P-1:0] rem_q;
    logic [XLEN_P-1:0] quo_q;
    logic [XLEN_P-1:0] div_q;
    logic [CNT_W-1:0]  cnt;
    logic              is_rem_q;
    logic              neg_q;
    logic              neg_r;
    logic              done_q;
    logic              ready_q;
    logic [XLEN_P-1:0] result_q;

    logic              is_signed;
    logic              is_rem;
    logic              sign_a;
    logic              sign_b;
    logic [XLEN_P-1:0] abs_a;
    logic [XLEN_P-1:0] abs_b;
    logic              div_zero;
    logic              overflow;
    logic [XLEN_P-1:0] special_result;
    logic [XLEN_P-1:0] fix_sel;
    logic              fix_neg;
    logic [XLEN_P-1:0] fix_val;
    logic [XLEN_P-1:0] step_rem;
    logic              step_bit;
    logic              unused_funct3_msb;

    // Every valid divide encoding has funct3[2] set, so only the low two bits steer the op.
    assign unused_funct3_msb = funct3[2];

    // Operand decode in IDLE: magnitudes, sign bookkeeping and the early-exit special cases.
    always_comb begin
        is_signed = ~funct3[0];
        is_rem    = funct3[1];
        sign_a    = is_signed & dividend[XLEN_P-1];
        sign_b    = is_signed & divisor[XLEN_P-1];
        abs_a     = sign_a ? -dividend : dividend;
        abs_b     = sign_b ? -divisor : divisor;
        div_zero  = (divisor == '0);
        overflow  = is_signed & (dividend == MOST_NEG) & (divisor == '1);
        if (div_zero) begin
            special_result = is_rem ? dividend : '1;
        end else begin
            special_result = is_rem ? '0 : dividend;
        end
    end

    // Final selection and sign correction applied in the FIX cycle.
    always_comb begin
        fix_sel = is_rem_q ? rem_q : quo_q;
        fix_neg = is_rem_q ? neg_r : neg_q;
        fix_val = fix_neg ? -fix_sel : fix_sel;
    end

    div_restore_step #(.W(XLEN_P)) u_step (
        .rem      (rem_q),
        .quo_msb  (quo_q[XLEN_P-1]),
        .divisor  (div_q),
        .next_rem (step_rem),
        .q_bit    (step_bit)
    );

    // Control FSM and datapath registers; flush wins over everything except reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rem_q    <= '0;
            quo_q    <= '0;
            div_q    <= '0;
            cnt      <= '0;
            is_rem_q <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            done_q   <= 1'b0;
            ready_q  <= 1'b1;
            result_q <= '0;
        end else if (flush) begin
            state   <= IDLE;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        ready_q  <= 1'b0;
                        is_rem_q <= is_rem;
                        neg_q    <= (sign_a ^ sign_b) & ~div_zero;
                        neg_r    <= sign_a;
                        rem_q    <= '0;
                        quo_q    <= abs_a;
                        div_q    <= abs_b;
                        cnt      <= '0;
                        if (div_zero || overflow) begin
                            result_q <= special_result;
                            done_q   <= 1'b1;
                            state    <= DONE;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem_q <= step_rem;
                    quo_q <= {quo_q[XLEN_P-2:0], step_bit};
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST_CNT) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    result_q <= fix_val;
                    done_q   <= 1'b1;
                    state    <= DONE;
                end
                DONE: begin
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state   <= IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state   <= IDLE;
                end
            endcase
        end
    end

    // A flush arriving in the DONE cycle must still swallow the pulse.
    assign done   = done_q & ~flush;
    assign ready  = ready_q;
    assign result = result_q;

endmodule

// File: tb/tb_m_ext_iter_divider.sv
// Directed self-checking bench for the iterative RV32M divider.
module tb_m_ext_iter_divider;
    import rv32m_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        flush;
    logic [2:0]  funct3;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        ready;
    logic        done;
    logic [31:0] result;

    int total = 0;
    int bad   = 0;

    m_ext_iter_divider dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .flush    (flush),
        .funct3   (funct3),
        .dividend (dividend),
        .divisor  (divisor),
        .ready    (ready),
        .done     (done),
        .result   (result)
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one operation next cycle and wait (bounded) for done; operands are scrambled after acceptance.
    task automatic apply_stimulus(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                                  output int lat, output logic [31:0] res, output logic busy_ok);
        step;
        funct3   = f;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        lat      = 0;
        res      = 32'hDEAD_BEEF;
        busy_ok  = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            step;
            start    = 1'b0;
            dividend = $urandom;
            divisor  = $urandom;
            if (done === 1'b1) begin
                lat = k;
                res = result;
                break;
            end
            if (ready !== 1'b0) busy_ok = 1'b0;
        end
    endtask

    task automatic run_check(input string tag, input logic [2:0] f, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
        int          lat;
        logic [31:0] res;
        logic        busy_ok;
        apply_stimulus(f, a, b, lat, res, busy_ok);
        check_output({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check_output({tag, "_res"}, res, exp_res);
    endtask

    initial begin
        int          lat;
        logic [31:0] res;
        logic [31:0] prev;
        logic        busy_ok;
        logic        saw_done;

        rst_n    = 1'b0;
        start    = 1'b0;
        flush    = 1'b0;
        funct3   = M_DIVU;
        dividend = '0;
        divisor  = '0;
        #12;
        check_output("rst_ready",  {31'b0, ready}, 32'd1);
        check_output("rst_done",   {31'b0, done},  32'd0);
        check_output("rst_result", result,         32'd0);
        step;
        rst_n = 1'b1;

        // Basic unsigned quotient with latency and busy window.
        apply_stimulus(M_DIVU, 32'd100, 32'd7, lat, res, busy_ok);
        check_output("divu_100_7_lat", 32'(lat), 32'd34);
        check_output("divu_100_7_res", res, 32'd14);
        check_output("divu_busy", {31'b0, busy_ok}, 32'd1);

        run_check("remu_100_7", M_REMU, 32'd100, 32'd7, 32'd2, 34);
        run_check("div_m7_2",   M_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
        run_check("rem_m7_2",   M_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
        run_check("rem_7_m2",   M_REM,  32'd7, 32'hFFFF_FFFE, 32'd1, 34);
        run_check("divu_big",   M_DIVU, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 34);
        run_check("remu_big",   M_REMU, 32'hFFFF_FFFF, 32'h10, 32'hF, 34);

        // Divide by zero and signed overflow finish the cycle after start.
        run_check("divu_by0", M_DIVU, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 1);
        run_check("rem_by0",  M_REM,  32'h1234_5678, 32'd0, 32'h1234_5678, 1);
        run_check("div_ovf",  M_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_check("rem_ovf",  M_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);

        // Flush during CALC: no pulse, back to IDLE next cycle, result untouched.
        step;
        prev     = result;
        funct3   = M_DIVU;
        dividend = 32'd1000;
        divisor  = 32'd3;
        start    = 1'b1;
        saw_done = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step;
            start = 1'b0;
            if (done === 1'b1) saw_done = 1'b1;
            if (k == 10) flush = 1'b1;
        end
        step;
        flush = 1'b0;
        if (done === 1'b1) saw_done = 1'b1;
        check_output("flush_ready",  {31'b0, ready},    32'd1);
        check_output("flush_result", result,            prev);
        check_output("flush_nodone", {31'b0, saw_done}, 32'd0);
        run_check("after_flush_9_3", M_DIVU, 32'd9, 32'd3, 32'd3, 34);

        // Flush in the DONE cycle of a divide-by-zero suppresses the pulse.
        step;
        funct3   = M_DIVU;
        dividend = 32'd5;
        divisor  = 32'd0;
        start    = 1'b1;
        step;
        start = 1'b0;
        flush = 1'b1;
        #1;
        check_output("flush_in_done", {31'b0, done}, 32'd0);
        step;
        flush = 1'b0;
        check_output("flush_in_done_ready", {31'b0, ready}, 32'd1);

        // Start and operand changes while busy are ignored.
        step;
        funct3   = M_DIVU;
        dividend = 32'd100;
        divisor  = 32'd7;
        start    = 1'b1;
        lat      = 0;
        res      = 32'hDEAD_BEEF;
        for (int k = 1; k <= 60; k++) begin
            step;
            start = 1'b0;
            if (k >= 5) begin
                start    = 1'b1;
                funct3   = M_REM;
                dividend = 32'd9;
                divisor  = 32'd1;
            end
            if (done === 1'b1) begin
                lat   = k;
                res   = result;
                start = 1'b0;
                break;
            end
        end
        start = 1'b0;
        check_output("busy_start_lat", 32'(lat), 32'd34);
        check_output("busy_start_res", res, 32'd14);
        step;
        step;
        check_output("start_not_queued", {31'b0, ready}, 32'd1);

        // Reset mid-operation clears everything immediately and never produces done.
        step;
        funct3   = M_DIVU;
        dividend = 32'd1000;
        divisor  = 32'd3;
        start    = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step;
            start = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        check_output("midrst_ready",  {31'b0, ready}, 32'd1);
        check_output("midrst_done",   {31'b0, done},  32'd0);
        check_output("midrst_result", result,         32'd0);
        step;
        rst_n    = 1'b1;
        saw_done = 1'b0;
        for (int k = 0; k < 50; k++) begin
            step;
            if (done === 1'b1) saw_done = 1'b1;
        end
        check_output("midrst_nodone", {31'b0, saw_done}, 32'd0);
        run_check("post_rst_div", M_DIV, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 34);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
